bf16_addsub_seq: RTL and testbench
==================================

# bf16_addsub_seq

Multi-cycle sequencer for one bfloat16 add/subtract operation. It accepts an operand pair over a valid/ready handshake, then steps a single shared datapath through swap/align, add, iterative normalize and round, and returns the result over a second valid/ready handshake. It sits between the issue logic and the bfloat16 register/writeback stage. One operation is in flight at a time.

## Interface
- No parameters.
- clk  in  1  sole clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  high exactly when state is IDLE.
- in_a  in  16  bf16 operand A: sign[15], exp[14:7], frac[6:0].
- in_b  in  16  bf16 operand B.
- in_op  in  1  0 = A+B, 1 = A−B.
- out_valid  out  1  result valid; high in DONE.
- out_ready  in  1  consumer accepts the result.
- out_result  out  16  bf16 result; held stable while out_valid.
- out_zero  out  1  result is ±0.
- out_ovf  out  1  finite operands overflowed to ±inf.
- busy  out  1  state is not IDLE.

## Operation
- States: IDLE, ALIGN, ADD, NORM, ROUND, DONE.
- IDLE: when in_valid is high, register in_a, in_b and in_op, then go to ALIGN.
- Operand encoding:
  - exp==0 is zero; frac is ignored (denormals flush to zero).
  - exp==255 with frac!=0 is NaN; exp==255 with frac==0 is inf.
  - Significand is {hidden, frac}; hidden = (exp!=0).
  - Extended significand is 11 bits: {significand, G, R, S}.
- ALIGN (1 cycle):
  - Effective B sign = b.sign ^ op. Effective subtract = a.sign ^ effective B sign.
  - Special cases go straight to DONE:
    - any NaN → 0x7FC0;
    - inf − inf (effective) → 0x7FC0;
    - a single inf → that inf, carrying its effective sign.
  - Otherwise, L is the operand with the larger {exp,frac}; ties pick A.
  - Shift S right by d = min(expL−expS, 11). OR all shifted-out bits into bit S.
- ADD (1 cycle): 12-bit sum {carry, 11 bits} = L ± S. Result sign = sign of L.
- NORM (1 cycle per step):
  - carry set: shift right 1 (sticky preserved), exp+1, go to ROUND.
  - sum==0: result is +0, go to ROUND.
  - bit10 set: go to ROUND.
  - otherwise: shift left 1, exp−1, stay in NORM.
  - If a left shift is needed while exp==1, flush to +0 and go to ROUND.
- ROUND (1 cycle):
  - Apply the rounding mode (see Configuration).
  - Significand overflow from rounding: shift right, exp+1.
  - exp reaching 255: ±inf (0x7F80 / 0xFF80), out_ovf=1.
  - Load out_result, out_zero and out_ovf, then go to DONE.
- Both operands zero: result sign = a.sign & effective B sign.
- Exact cancellation: result is +0 (0x0000).
- DONE: out_valid=1. On out_ready, go to IDLE.

## Timing
- Reset values: state IDLE, out_valid 0, out_result 0x0000, out_zero 0, out_ovf 0, busy 0, in_ready 1.
- Accept edge E0 is the edge where in_valid & in_ready.
- Normal path: ALIGN in cycle 1, ADD in cycle 2, NORM in cycles 3..3+k (k = number of left shifts), ROUND in cycle 4+k.
- out_valid first high in cycle 5+k. Range: k=0 gives 5, k=8 gives 13.
- Special-value path: out_valid high in cycle 2.
- Backpressure: DONE holds out_valid, out_result and flags indefinitely until out_ready.
- in_ready is 0 from the cycle after E0 until the cycle after the output handshake. There is no overlap between operations.
- rst asserted in any state returns to IDLE on that edge and drops the in-flight operation. No result is emitted.
- in_valid outside IDLE is ignored. in_a/in_b may change freely once accepted.

## Configuration
- BF16_RNE_EN defined: round-to-nearest-even. Increment when G & (R | S | lsb).
- BF16_RNE_EN undefined: truncate, discarding G, R and S. ROUND still takes one cycle, so latency is unchanged.

## Test plan
- 0x3F80 + 0x3F80 (op=0) → 0x4000, out_zero=0, out_valid 5 cycles after accept (carry path, k=0).
- 0x3FC0 − 0x3F80 (op=1) → 0x3F00, out_valid 6 cycles after accept (k=1). Then 0x3F80 − 0x3F80 → 0x0000, out_zero=1.
- 0x7F7F + 0x7F7F → 0x7F80, out_ovf=1. 0x7F80 − 0x7F80 → 0x7FC0, out_valid 2 cycles after accept. 0x7FC1 + 0x3F80 → 0x7FC0.
- 0x3F81 + 0x3B80 → 0x3F82 with BF16_RNE_EN, 0x3F81 without. 0x3F80 + 0x3B80 → 0x3F80 in both builds (tie to even).
- Hold out_ready=0 for 10 cycles: out_valid and out_result stay stable and in_ready stays 0. Raise out_ready: IDLE and in_ready=1 on the next cycle.
- Assert rst for one cycle while in NORM: next cycle shows IDLE, out_valid=0, in_ready=1. A new operation issued immediately afterwards completes correctly.

Source files
------------

// File: rtl/bf16_addsub_seq.sv
// Multi-cycle bfloat16 add/subtract: one operation walks ALIGN, ADD, NORM and ROUND on a shared datapath.
// Define BF16_RNE_EN for round-to-nearest-even; without it the result is truncated.
module bf16_addsub_seq (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_a,
   input  logic [15:0] in_b,
   input  logic        in_op,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_result,
   output logic        out_zero,
   output logic        out_ovf,
   output logic        busy
);
   typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND, DONE} state_t;

   state_t      state_q, state_d;
   logic [15:0] a_q, a_d, b_q, b_d;
   logic        op_q, op_d;
   logic        sign_q, sign_d;
   logic        sub_q, sub_d;
   logic        bz_q, bz_d;
   logic        zero_q, zero_d;
   logic [8:0]  exp_q, exp_d;
   logic [10:0] lg_q, lg_d, sm_q, sm_d;
   logic [11:0] sum_q, sum_d;
   logic [15:0] res_q, res_d;
   logic        rzero_q, rzero_d;
   logic        ovf_q, ovf_d;

   logic        eb_s, eff_sub, a_nan, b_nan, a_inf, b_inf, a_big;
   logic [10:0] a_x, b_x, s_x, s_al;
   logic [7:0]  diff;
   logic [3:0]  d_sh;
   logic [21:0] sh;
   logic        inc;
   logic [7:0]  frac_sum;
   logic [8:0]  exp_r;

   assign eb_s    = b_q[15] ^ op_q;
   assign eff_sub = a_q[15] ^ eb_s;
   assign a_nan   = (&a_q[14:7]) & (|a_q[6:0]);
   assign b_nan   = (&b_q[14:7]) & (|b_q[6:0]);
   assign a_inf   = (&a_q[14:7]) & ~(|a_q[6:0]);
   assign b_inf   = (&b_q[14:7]) & ~(|b_q[6:0]);
   assign a_big   = (a_q[14:0] >= b_q[14:0]);
   assign a_x     = (a_q[14:7] != 8'd0) ? {1'b1, a_q[6:0], 3'b000} : 11'd0;
   assign b_x     = (b_q[14:7] != 8'd0) ? {1'b1, b_q[6:0], 3'b000} : 11'd0;
   assign diff    = a_big ? (a_q[14:7] - b_q[14:7]) : (b_q[14:7] - a_q[14:7]);
   assign d_sh    = (diff > 8'd11) ? 4'd11 : diff[3:0];
   assign s_x     = a_big ? b_x : a_x;
   // Everything pushed below bit 0 of the aligned operand collapses into the sticky bit.
   assign sh      = {s_x, 11'd0} >> d_sh;
   assign s_al    = {sh[21:12], sh[11] | (|sh[10:0])};

`ifdef BF16_RNE_EN
   assign inc = sum_q[2] & (sum_q[1] | sum_q[0] | sum_q[3]);
`else
   assign inc = 1'b0;
`endif
   // Hidden bit is always 1 here, so a carry out of the fraction means 1.111..1 rolled over.
   assign frac_sum = {1'b0, sum_q[9:3]} + {7'd0, inc};
   assign exp_r    = exp_q + {8'd0, frac_sum[7]};

   always_comb begin
      // NOTE: every next-state value starts as its current value, so no branch can infer a latch.
      state_d = state_q;
      a_d = a_q;  b_d = b_q;  op_d = op_q;
      sign_d = sign_q;  sub_d = sub_q;  bz_d = bz_q;  zero_d = zero_q;
      exp_d = exp_q;  lg_d = lg_q;  sm_d = sm_q;  sum_d = sum_q;
      res_d = res_q;  rzero_d = rzero_q;  ovf_d = ovf_q;
      unique case (state_q)
         IDLE: if (in_valid) begin
            a_d = in_a;  b_d = in_b;  op_d = in_op;
            state_d = ALIGN;
         end
         ALIGN: begin
            sub_d   = eff_sub;
            sign_d  = a_big ? a_q[15] : eb_s;
            exp_d   = {1'b0, a_big ? a_q[14:7] : b_q[14:7]};
            lg_d    = a_big ? a_x : b_x;
            sm_d    = s_al;
            bz_d    = (a_q[14:7] == 8'd0) && (b_q[14:7] == 8'd0);
            zero_d  = 1'b0;
            state_d = ADD;
            if (a_nan || b_nan || (a_inf && b_inf && eff_sub)) begin
               res_d = 16'h7FC0;  rzero_d = 1'b0;  ovf_d = 1'b0;  state_d = DONE;
            end else if (a_inf) begin
               res_d = {a_q[15], 15'h7F80};  rzero_d = 1'b0;  ovf_d = 1'b0;  state_d = DONE;
            end else if (b_inf) begin
               res_d = {eb_s, 15'h7F80};  rzero_d = 1'b0;  ovf_d = 1'b0;  state_d = DONE;
            end
         end
         ADD: begin
            sum_d   = sub_q ? ({1'b0, lg_q} - {1'b0, sm_q}) : ({1'b0, lg_q} + {1'b0, sm_q});
            state_d = NORM;
         end
         NORM: begin
            if (sum_q[11]) begin
               sum_d   = {1'b0, sum_q[11:2], |sum_q[1:0]};
               exp_d   = exp_q + 9'd1;
               state_d = ROUND;
            end else if (sum_q == 12'd0) begin
               zero_d  = 1'b1;
               state_d = ROUND;
            end else if (sum_q[10]) begin
               state_d = ROUND;
            end else if (exp_q == 9'd1) begin
               zero_d  = 1'b1;
               bz_d    = 1'b0;
               state_d = ROUND;
            end else begin
               sum_d = {1'b0, sum_q[9:0], 1'b0};
               exp_d = exp_q - 9'd1;
            end
         end
         ROUND: begin
            rzero_d = 1'b0;
            ovf_d   = 1'b0;
            state_d = DONE;
            if (zero_q) begin
               // Only a pair of zero operands keeps a sign; cancellation and flush give +0.
               res_d   = {bz_q & a_q[15] & eb_s, 15'd0};
               rzero_d = 1'b1;
            end else if (exp_r >= 9'd255) begin
               res_d = {sign_q, 15'h7F80};
               ovf_d = 1'b1;
            end else begin
               res_d = {sign_q, exp_r[7:0], frac_sum[6:0]};
            end
         end
         DONE: if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: non-blocking assignments so every register samples the values from before the edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         res_q   <= 16'h0000;
         rzero_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         res_q   <= res_d;
         rzero_q <= rzero_d;
         ovf_q   <= ovf_d;
      end
   end

   // NOTE: datapath registers carry no reset; each is written on the way to the state that reads it.
   always_ff @(posedge clk) begin
      a_q <= a_d;  b_q <= b_d;  op_q <= op_d;
      sign_q <= sign_d;  sub_q <= sub_d;  bz_q <= bz_d;  zero_q <= zero_d;
      exp_q <= exp_d;  lg_q <= lg_d;  sm_q <= sm_d;  sum_q <= sum_d;
   end

   assign in_ready   = (state_q == IDLE);
   assign busy       = (state_q != IDLE);
   assign out_valid  = (state_q == DONE);
   assign out_result = res_q;
   assign out_zero   = rzero_q;
   assign out_ovf    = ovf_q;
endmodule

// File: tb/tb_bf16_addsub_seq.sv
// Self-checking bench for bf16_addsub_seq: exact-arithmetic reference model, directed corner cases,
// backpressure, mid-operation reset and randomized operand pairs. Honors BF16_RNE_EN like the RTL.
module tb_bf16_addsub_seq;
   logic        clk, rst, in_valid, in_ready, in_op, out_valid, out_ready, out_zero, out_ovf, busy;
   logic [15:0] in_a, in_b, out_result;

   bf16_addsub_seq dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_op(in_op),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_zero(out_zero), .out_ovf(out_ovf), .busy(busy)
   );

   typedef struct {
      logic [15:0] res;
      logic        zero;
      logic        ovf;
      int          lat;
   } exp_t;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        op;
      logic [15:0] res;
      logic        zero;
      logic        ovf;
      int          lat;
   } vec_t;

`ifdef BF16_RNE_EN
   localparam logic [15:0] EXP_3F81 = 16'h3F82;
`else
   localparam logic [15:0] EXP_3F81 = 16'h3F81;
`endif

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Reference: exact sum of the two values, then rounded once. Operands far apart keep only
   // a tiny nonzero residue for the smaller one, which rounds identically to the exact value.
   function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic op);
      exp_t r;
      int ea, eb, el, es, dc, p, s, e;
      logic sa, sbe, sl, sub, a_big;
      longint unsigned sig_a, sig_b, ml, ms, v, m, rem, half;
      ea = int'(a[14:7]);  eb = int'(b[14:7]);
      sa = a[15];  sbe = b[15] ^ op;  sub = sa ^ sbe;
      r.res = 16'h0000;  r.zero = 1'b0;  r.ovf = 1'b0;  r.lat = 5;
      if ((ea == 255 && a[6:0] != 7'd0) || (eb == 255 && b[6:0] != 7'd0)) begin
         r.res = 16'h7FC0;  r.lat = 2;  return r;
      end
      if (ea == 255 && eb == 255) begin
         r.res = sub ? 16'h7FC0 : {sa, 15'h7F80};  r.lat = 2;  return r;
      end
      if (ea == 255) begin r.res = {sa, 15'h7F80};  r.lat = 2;  return r; end
      if (eb == 255) begin r.res = {sbe, 15'h7F80}; r.lat = 2;  return r; end
      if (ea == 0 && eb == 0) begin
         r.res = {sa & sbe, 15'd0};  r.zero = 1'b1;  return r;
      end
      sig_a = (ea != 0) ? 64'(128 + int'(a[6:0])) : 64'd0;
      sig_b = (eb != 0) ? 64'(128 + int'(b[6:0])) : 64'd0;
      a_big = (a[14:0] >= b[14:0]);
      el = a_big ? ea : eb;  es = a_big ? eb : ea;
      sl = a_big ? sa : sbe;
      ml = a_big ? sig_a : sig_b;  ms = a_big ? sig_b : sig_a;
      dc = (el - es > 40) ? 40 : el - es;
      ml = ml << dc;
      v  = sub ? ml - ms : ml + ms;
      if (v == 64'd0) begin r.zero = 1'b1;  return r; end
      p = 0;
      for (int i = 0; i < 64; i++) if (v[i]) p = i;
      e = el - dc + p - 7;
      s = 7 + dc - p;
      if (s < 0) s = 0;
      r.lat = 5 + ((s > el - 1) ? el - 1 : s);
      if (e < 1) begin r.zero = 1'b1;  return r; end
      rem = 64'd0;  half = 64'd0;
      if (p >= 7) begin
         m = v >> (p - 7);
         rem = v & ((64'd1 << (p - 7)) - 64'd1);
         if (p >= 8) half = 64'd1 << (p - 8);
      end else begin
         m = v << (7 - p);
      end
`ifdef BF16_RNE_EN
      if (p >= 8 && (rem > half || (rem == half && m[0]))) m = m + 64'd1;
`endif
      if (m == 64'd256) begin m = 64'd128;  e = e + 1; end
      if (e >= 255) begin
         r.res = {sl, 15'h7F80};  r.ovf = 1'b1;
      end else begin
         r.res = {sl, 8'(e), m[6:0]};
      end
      return r;
   endfunction

   // Compare process: every cycle a result is presented it must match the oldest expectation.
   always @(negedge clk) begin
      if (!rst && out_valid) begin
         if (exp_q.size() == 0) begin
            check("unexpected_out_valid", 32'(out_valid), 32'd0);
         end else begin
            check("out_result", 32'(out_result), 32'(exp_q[0].res));
            check("out_zero", 32'(out_zero), 32'(exp_q[0].zero));
            check("out_ovf", 32'(out_ovf), 32'(exp_q[0].ovf));
            check("in_ready_in_done", 32'(in_ready), 32'd0);
            if (out_ready) void'(exp_q.pop_front());
         end
      end
   end

   task automatic send(input logic [15:0] a, input logic [15:0] b, input logic op);
      int n;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) check("ready_timeout", 32'(in_ready), 32'd1);
      in_a = a;  in_b = b;  in_op = op;  in_valid = 1'b1;
      exp_q.push_back(model(a, b, op));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_a = 16'($urandom);  in_b = 16'($urandom);  in_op = 1'($urandom);
   endtask

   // Returns the cycle index (accept edge = cycle 0) in which out_valid is first seen.
   task automatic wait_valid(output int lat);
      lat = 1;
      @(negedge clk);
      while (!out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      if (!out_valid) check("valid_timeout", 32'(out_valid), 32'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got still running, expected finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t dir [0:11];
      exp_t e;
      int   lat;
      logic [15:0] ra, rb;
      logic rop;
      int   mode;

      dir[0]  = '{16'h3F80, 16'h3F80, 1'b0, 16'h4000, 1'b0, 1'b0, 5};
      dir[1]  = '{16'h3FC0, 16'h3F80, 1'b1, 16'h3F00, 1'b0, 1'b0, 6};
      dir[2]  = '{16'h3F80, 16'h3F80, 1'b1, 16'h0000, 1'b1, 1'b0, 5};
      dir[3]  = '{16'h7F7F, 16'h7F7F, 1'b0, 16'h7F80, 1'b0, 1'b1, 5};
      dir[4]  = '{16'h7F80, 16'h7F80, 1'b1, 16'h7FC0, 1'b0, 1'b0, 2};
      dir[5]  = '{16'h7FC1, 16'h3F80, 1'b0, 16'h7FC0, 1'b0, 1'b0, 2};
      dir[6]  = '{16'h3F81, 16'h3B80, 1'b0, EXP_3F81, 1'b0, 1'b0, 5};
      dir[7]  = '{16'h3F80, 16'h3B80, 1'b0, 16'h3F80, 1'b0, 1'b0, 5};
      dir[8]  = '{16'h8000, 16'h8000, 1'b0, 16'h8000, 1'b1, 1'b0, 5};
      dir[9]  = '{16'h00C0, 16'h0080, 1'b1, 16'h0000, 1'b1, 1'b0, 5};
      dir[10] = '{16'h3F80, 16'hFF80, 1'b1, 16'h7F80, 1'b0, 1'b0, 2};
      dir[11] = '{16'h8000, 16'h0000, 1'b1, 16'h8000, 1'b1, 1'b0, 5};

      rst = 1'b1;  in_valid = 1'b0;  in_a = 16'd0;  in_b = 16'd0;  in_op = 1'b0;  out_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_result", 32'(out_result), 32'h0000);
      check("rst_out_zero", 32'(out_zero), 32'd0);
      check("rst_out_ovf", 32'(out_ovf), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      rst = 1'b0;

      foreach (dir[i]) begin
         e = model(dir[i].a, dir[i].b, dir[i].op);
         check($sformatf("model_res_%0d", i), 32'(e.res), 32'(dir[i].res));
         check($sformatf("model_zero_%0d", i), 32'(e.zero), 32'(dir[i].zero));
         check($sformatf("model_ovf_%0d", i), 32'(e.ovf), 32'(dir[i].ovf));
         check($sformatf("model_lat_%0d", i), 32'(e.lat), 32'(dir[i].lat));
         send(dir[i].a, dir[i].b, dir[i].op);
         wait_valid(lat);
         check($sformatf("latency_%0d", i), 32'(lat), 32'(dir[i].lat));
      end

      // Backpressure: result must sit still for 10 cycles while out_ready is low.
      @(posedge clk);
      #1 out_ready = 1'b0;
      send(16'h4000, 16'h3F80, 1'b0);
      wait_valid(lat);
      check("bp_latency", 32'(lat), 32'd5);
      repeat (10) begin
         @(negedge clk);
         check("bp_out_valid", 32'(out_valid), 32'd1);
         check("bp_out_result", 32'(out_result), 32'h4040);
         check("bp_in_ready", 32'(in_ready), 32'd0);
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("bp_release_in_ready", 32'(in_ready), 32'd1);
      check("bp_release_out_valid", 32'(out_valid), 32'd0);

      // Reset in the middle of a 7-step normalization drops the operation.
      send(16'h3F81, 16'h3F80, 1'b1);
      repeat (4) @(negedge clk);
      check("norm_busy", 32'(busy), 32'd1);
      check("norm_out_valid", 32'(out_valid), 32'd0);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      void'(exp_q.pop_back());
      @(negedge clk);
      check("mid_rst_in_ready", 32'(in_ready), 32'd1);
      check("mid_rst_out_valid", 32'(out_valid), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      e = model(16'h3F81, 16'h3F80, 1'b1);
      check("model_res_k7", 32'(e.res), 32'h3C00);
      check("model_lat_k7", 32'(e.lat), 32'd12);
      send(16'h3F81, 16'h3F80, 1'b1);
      wait_valid(lat);
      check("post_rst_latency", 32'(lat), 32'd12);

      for (int n = 0; n < 300; n++) begin
         ra = 16'($urandom);  rb = 16'($urandom);  rop = 1'($urandom);
         mode = int'($urandom_range(0, 3));
         if (mode == 0) begin
            rb[14:7] = ra[14:7];
         end else if (mode == 1) begin
            rb[14:7] = ra[14:7] + 8'($urandom_range(0, 12));
         end else if (mode == 2) begin
            ra[14:7] = 8'($urandom_range(1, 4));
            rb[14:7] = 8'($urandom_range(0, 4));
         end
         e = model(ra, rb, rop);
         send(ra, rb, rop);
         wait_valid(lat);
         check($sformatf("rand_latency_%0d", n), 32'(lat), 32'(e.lat));
      end

      @(posedge clk);
      @(negedge clk);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
